// File: rtl/adc.sv
// Counter-based ADC datapath: comparator synchronizer, settle-delay timer,
// saturating conversion counter and output latch, sequenced by an external FSM.
module adc #(
  parameter int WIDTH        = 8,
  parameter int DELAY_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             counter_en,
  input  logic             latch_en,
  input  logic             delay_en,
  input  logic             reset_counter,
  input  logic             compared_value,
  output logic             delay_completed,
  output logic             of_r,
  output logic [WIDTH-1:0] pwm_r
);

  localparam int            DW        = $clog2(DELAY_CYCLES + 1);
  localparam logic [DW-1:0] DELAY_MAX = DW'(DELAY_CYCLES);

  logic             sync_q;
  logic             cmp_s;
  logic [DW-1:0]    delay_cnt;
  logic [WIDTH-1:0] cnt;
  logic             ovf;

  assign delay_completed = (delay_cnt == DELAY_MAX);

  // The comparator is asynchronous to clk, so it is only ever used after two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      cmp_s  <= 1'b0;
    end else begin
      sync_q <= compared_value;
      cmp_s  <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_cnt <= '0;
    end else if (!delay_en) begin
      delay_cnt <= '0;
    end else if (delay_cnt != DELAY_MAX) begin
      delay_cnt <= delay_cnt + 1'b1;
    end
  end

  // Counter saturates at all-ones instead of wrapping; ovf stays set until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (reset_counter) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (counter_en && cmp_s) begin
      if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r <= '0;
      of_r  <= 1'b0;
    end else if (latch_en) begin
      pwm_r <= cnt;
      of_r  <= ovf;
    end
  end

endmodule

// File: tb/tb_adc.sv
// Randomized and directed bench for adc, checked against a cycle-level
// behavioural model built from integer arithmetic and a comparator history queue.
module tb_adc;

  localparam int WIDTH = 8;
  localparam int DC    = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             counter_en = 1'b0;
  logic             latch_en = 1'b0;
  logic             delay_en = 1'b0;
  logic             reset_counter = 1'b0;
  logic             compared_value = 1'b0;
  logic             delay_completed;
  logic             of_r;
  logic [WIDTH-1:0] pwm_r;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_run;
  int m_cnt;
  bit m_ovf;
  int m_pwm;
  bit m_of;
  bit cvq[$];

  adc #(.WIDTH(WIDTH), .DELAY_CYCLES(DC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .counter_en(counter_en),
    .latch_en(latch_en),
    .delay_en(delay_en),
    .reset_counter(reset_counter),
    .compared_value(compared_value),
    .delay_completed(delay_completed),
    .of_r(of_r),
    .pwm_r(pwm_r)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_run = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_pwm = 0;
    m_of  = 0;
    cvq.delete();
    cvq.push_back(1'b0);
    cvq.push_back(1'b0);
  endtask

  // One clock edge with the given controls; model advances, then all outputs are compared.
  task automatic applyStimulus(input bit ce, input bit le, input bit de, input bit rc,
                               input bit cv, input string tag);
    bit cmp;
    counter_en     = ce;
    latch_en       = le;
    delay_en       = de;
    reset_counter  = rc;
    compared_value = cv;
    @(posedge clk);
    cmp = cvq.pop_front();
    cvq.push_back(cv);
    if (le) begin
      m_pwm = m_cnt;
      m_of  = m_ovf;
    end
    if (rc) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (ce && cmp) begin
      if (m_cnt == MAXV) m_ovf = 1;
      else m_cnt = m_cnt + 1;
    end
    m_run = de ? ((m_run < DC) ? m_run + 1 : DC) : 0;
    #1;
    checkOutput({tag, "_dc"}, int'(delay_completed), int'(m_run == DC));
    checkOutput({tag, "_pwm"}, int'(pwm_r), m_pwm);
    checkOutput({tag, "_of"}, int'(of_r), int'(m_of));
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #2;
    checkOutput({tag, "_rst_dc"}, int'(delay_completed), 0);
    checkOutput({tag, "_rst_pwm"}, int'(pwm_r), 0);
    checkOutput({tag, "_rst_of"}, int'(of_r), 0);
    modelReset();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bit de_r, cv_r;
    modelReset();
    #3;
    checkOutput("por_dc", int'(delay_completed), 0);
    checkOutput("por_pwm", int'(pwm_r), 0);
    checkOutput("por_of", int'(of_r), 0);
    rst_n = 1'b1;

    // Settle delay with reset_counter held
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 0, 1, 1, 0, "dly");
      checkOutput("dly_lit", int'(delay_completed), int'(i >= DC));
    end
    applyStimulus(0, 0, 0, 0, 0, "dly_off");
    checkOutput("dly_drop", int'(delay_completed), 0);

    // Basic count of 10
    applyStimulus(0, 0, 0, 1, 1, "basic_clr");
    applyStimulus(0, 0, 0, 0, 1, "basic_pre");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 1, "basic_cnt");
    applyStimulus(0, 1, 0, 0, 1, "basic_lat");
    checkOutput("basic_pwm10", int'(pwm_r), 10);
    checkOutput("basic_of0", int'(of_r), 0);

    // Comparator falls after count 5; two more counts slip through the synchronizer
    applyStimulus(0, 0, 0, 1, 1, "stop_clr");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1, "stop_cnt");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, "stop_low");
    applyStimulus(0, 1, 0, 0, 0, "stop_lat");
    checkOutput("stop_pwm7", int'(pwm_r), 7);

    // Overflow saturation, then clear
    applyStimulus(0, 0, 0, 1, 1, "ovf_clr");
    applyStimulus(0, 0, 0, 0, 1, "ovf_pre");
    for (int i = 0; i < 300; i++) applyStimulus(1, 0, 0, 0, 1, "ovf_cnt");
    applyStimulus(0, 1, 0, 0, 1, "ovf_lat");
    checkOutput("ovf_pwm255", int'(pwm_r), MAXV);
    checkOutput("ovf_of1", int'(of_r), 1);
    applyStimulus(0, 0, 0, 1, 1, "ovf_rc");
    applyStimulus(0, 1, 0, 0, 1, "ovf_lat2");
    checkOutput("ovf_pwm0", int'(pwm_r), 0);
    checkOutput("ovf_of0", int'(of_r), 0);

    // Latch on the same edge as an increment
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 1, "sim_cnt");
    applyStimulus(1, 1, 0, 0, 1, "sim_latinc");
    checkOutput("sim_pwm20", int'(pwm_r), 20);
    applyStimulus(0, 1, 0, 0, 1, "sim_lat21");
    checkOutput("sim_pwm21", int'(pwm_r), 21);

    // Latch on the same edge as a clear
    applyStimulus(0, 0, 0, 1, 1, "sim_clr");
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0, 1, "sim_cnt9");
    applyStimulus(0, 1, 0, 1, 1, "sim_latclr");
    checkOutput("sim_pwm9", int'(pwm_r), 9);
    applyStimulus(0, 1, 0, 0, 1, "sim_lat0");
    checkOutput("sim_pwm0", int'(pwm_r), 0);

    // Async reset mid-count with delay elapsed and a nonzero latched value
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, 0, 1, "ar_cnt");
    applyStimulus(1, 1, 1, 0, 1, "ar_lat");
    checkOutput("ar_pre_pwm", int'(pwm_r), 6);
    pulseReset("ar");
    applyStimulus(0, 1, 0, 0, 0, "ar_post");
    checkOutput("ar_post_pwm", int'(pwm_r), 0);

    // Randomized traffic with persistent delay_en / comparator levels
    de_r = 1'b0;
    cv_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) de_r = ~de_r;
      if ($urandom_range(0, 5) == 0) cv_r = ~cv_r;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, de_r,
                    $urandom_range(0, 39) == 0, cv_r, "rnd");
      if ($urandom_range(0, 149) == 0) pulseReset("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
